ed25519_in_unpack: RTL
======================

Name: ed25519_in_unpack

Overview:
- Input front-end of the ed25519 point-multiplication datapath. Sits directly between the 64-bit valid/ready input port and the scalar-multiplication core.
- Collects 12 consecutive bus words into scalar k, base-point x and base-point y.
- Reduces both coordinates to canonical form mod p = 2^255-19.
- Presents all three 256-bit operands to the core with a single valid/ready handshake.

Parameters:
- DATA_W, 64: input bus width. Must divide PATN_W.
- PATN_W, 256: operand width.
- N_WORDS, 3*PATN_W/DATA_W (=12): words per job. Derived; do not override.

Ports:
- i_clk  in  1  clock; all state on rising edge.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_in_valid  in  1  input word valid.
- o_in_ready  out  1  block can accept a word.
- i_in_data  in  DATA_W  input word.
- o_out_valid  out  1  operand set valid to core.
- i_out_ready  in  1  core accepts operand set.
- o_scalar  out  PATN_W  scalar k, passed through unmodified.
- o_px  out  PATN_W  x mod p, canonical (< p).
- o_py  out  PATN_W  y mod p, canonical (< p).
- o_noncanon  out  1  high if the received x or y was >= p.

Behaviour:
- Reset (i_rst_n=0, any time, including mid-job):
  - State goes to S_LOAD; word counter = 0; all operand registers = 0.
  - o_in_ready=1, o_out_valid=0, o_noncanon=0.
  - Any partially received job is discarded.
- Word order (most-significant word first): words 0..3 are k[255:192]..k[63:0], words 4..7 are x (MSW first), words 8..11 are y (MSW first).
- A word transfers on a rising edge with i_in_valid & o_in_ready. The counter increments on each transfer.
- S_LOAD:
  - o_in_ready=1.
  - On the transfer of word 11: counter wraps to 0 and state goes to S_RED_X.
  - i_in_valid low is a stall; nothing changes.
- S_RED_X (one cycle):
  - o_in_ready=0.
  - x <= red(x); nc_x <= (x >= p). Go to S_RED_Y.
- S_RED_Y (one cycle):
  - o_in_ready=0.
  - y <= red(y); o_noncanon <= nc_x | (y >= p). Go to S_OUT.
- red(v): one shared combinational unit, used in both reduce states.
  - t = v[254:0] + 19*v[255] (t < 2^255+19).
  - Result = t-p if t >= p, else t. Result is always < p.
- S_OUT:
  - o_out_valid=1, o_in_ready=0.
  - o_scalar, o_px, o_py and o_noncanon are held stable while valid.
  - On i_out_ready: go to S_LOAD. o_out_valid falls on the next cycle; o_in_ready rises on the next cycle.
  - No input word is accepted in the handoff cycle.
- Latency: o_out_valid is high in the third cycle after the edge that transfers word 11 (S_RED_X, S_RED_Y, then S_OUT).
- Throughput: minimum 15 cycles per job (12 load + 2 reduce + 1 out).
- i_in_valid while o_in_ready=0 is ignored; i_in_data is don't-care then.
- i_out_ready while o_out_valid=0 is ignored.
- o_noncanon is cleared at the start of each new job (transfer of word 0).
- o_in_ready and o_out_valid come straight from the state register; no combinational path from inputs to outputs.

Test Plan:
- Reset, then 12 back-to-back words with k=1, x=9, y=0x2000...0, i_out_ready=1 → o_out_valid high 3 cycles after the last transfer; o_px=9; o_py unchanged; o_noncanon=0; o_in_ready high again the following cycle.
- x = p = 0x7FFF...FFED, y = p-1 → o_px=0, o_py=p-1, o_noncanon=1.
- x = 2^256-1, y = 2^255+5 → o_px=0x25 (37), o_py=0x18 (24), o_noncanon=1.
- Random i_in_valid and i_out_ready (50% duty), 3 consecutive jobs → words are never dropped or duplicated; outputs stay stable while o_out_valid=1 and i_out_ready=0; every job matches the golden model.
- Assert i_rst_n=0 asynchronously (mid-cycle) after word 6, then send a full job → o_in_ready=1 immediately; the counter restarts; the output reflects only the new job.
- Hold i_out_ready=0 for 20 cycles in S_OUT while i_in_valid=1 → o_in_ready stays 0; no word is consumed; the operands are unchanged.

Source files
------------

// File: rtl/ed25519_in_unpack.sv
// Input front-end of the ed25519 point-multiplication datapath: gathers k, x, y
// from the word bus, reduces x and y mod p = 2^255-19, and hands all three to the core.
module ed25519_in_unpack #(
    parameter int DATA_W = 64,
    parameter int PATN_W = 256,
    localparam int N_WORDS = 3 * PATN_W / DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [DATA_W-1:0] i_in_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [PATN_W-1:0] o_scalar,
    output logic [PATN_W-1:0] o_px,
    output logic [PATN_W-1:0] o_py,
    output logic              o_noncanon,
    output logic [1:0]        o_dbg_state
);
    // Handshakes: a beat moves on a rising edge where valid & ready are both
    // high; valid never waits on ready, and ready depends only on the state.

    localparam int CNT_W = $clog2(N_WORDS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_WORDS - 1);
    localparam logic [PATN_W-1:0] P = (PATN_W'(1) << (PATN_W - 1)) - PATN_W'(19);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_RED_X = 2'd1,
        S_RED_Y = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [CNT_W-1:0]  cnt;
    logic [PATN_W-1:0] k;
    logic [PATN_W-1:0] x;
    logic [PATN_W-1:0] y;
    logic              nc_x;
    logic              noncanon;
    logic              xfer;

    logic [PATN_W-1:0] red_in;
    logic [PATN_W-1:0] red_t;
    logic [PATN_W-1:0] red_out;
    logic              red_nc;

    // Single reduction unit shared by both reduce states: fold bit 255 back
    // in as +19, then at most one conditional subtract of p.
    always_comb begin
        red_in  = (state == S_RED_Y) ? y : x;
        red_t   = {1'b0, red_in[PATN_W-2:0]} + (red_in[PATN_W-1] ? PATN_W'(19) : '0);
        red_out = (red_t >= P) ? (red_t - P) : red_t;
        red_nc  = (red_in >= P);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_LOAD;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        o_in_ready  = 1'b0;
        o_out_valid = 1'b0;
        case (state)
            S_LOAD: begin
                o_in_ready = 1'b1;
                if (i_in_valid && cnt == LAST) state_nx = S_RED_X;
            end
            S_RED_X: state_nx = S_RED_Y;
            S_RED_Y: state_nx = S_OUT;
            S_OUT: begin
                o_out_valid = 1'b1;
                if (i_out_ready) state_nx = S_LOAD;
            end
            default: state_nx = S_LOAD;
        endcase
    end

    assign xfer = i_in_valid && (state == S_LOAD);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt      <= '0;
            k        <= '0;
            x        <= '0;
            y        <= '0;
            nc_x     <= 1'b0;
            noncanon <= 1'b0;
        end else begin
            if (xfer) begin
                // MSW-first stream: the k/x/y chain shifts left by one word per beat.
                {k, x, y} <= {k[PATN_W-DATA_W-1:0], x, y, i_in_data};
                cnt       <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
                if (cnt == '0) noncanon <= 1'b0;
            end
            if (state == S_RED_X) begin
                x    <= red_out;
                nc_x <= red_nc;
            end
            if (state == S_RED_Y) begin
                y        <= red_out;
                noncanon <= nc_x | red_nc;
            end
        end
    end

    assign o_scalar    = k;
    assign o_px        = x;
    assign o_py        = y;
    assign o_noncanon  = noncanon;
    assign o_dbg_state = state;

endmodule
